// File: rtl/mux_rr_selector.sv
// Round-robin 2:1 request arbiter driving the datapath mux select, with a one-entry registered output slot.
// Define MUX_BURST_EN to let a grant hold for up to BURST consecutive beats.
module mux_rr_selector #(
  parameter int W     = 1,
  parameter int BURST = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [1:0]   i_req,
  input  logic [W-1:0] i_din0,
  input  logic [W-1:0] i_din1,
  output logic [1:0]   o_ack,
  output logic         o_sel,
  output logic [W-1:0] o_y_data,
  output logic         o_y_valid,
  input  logic         i_y_ready,
  output logic         o_busy,
  output logic [1:0]   o_dbg_state
);

  // Handshakes: a beat moves when valid and ready are both high at a rising edge.
  // Sources: i_req is valid, o_ack is ready. Consumer: o_y_valid is valid, i_y_ready is ready.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_G0   = 2'd1;
  localparam logic [1:0] S_G1   = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic         r_sel;
  logic         r_lp;
  logic         r_y_valid;
  logic [W-1:0] r_y_data;
  logic         w_slot_free;
  logic [1:0]   w_ack;
  logic         w_k;
  logic         w_req_k;
  logic         w_req_o;
  logic         w_xfer;
  logic [1:0]   w_other;

  assign w_slot_free = !r_y_valid || i_y_ready;
  assign w_k         = (r_state == S_G1);
  assign w_req_k     = i_req[w_k];
  assign w_req_o     = i_req[~w_k];
  assign w_xfer      = |w_ack;
  assign w_other     = w_k ? S_G0 : S_G1;

`ifdef MUX_BURST_EN
  localparam int CW = $clog2(BURST) + 1;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_burst_done;

  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_burst_done = (w_cnt_inc >= CW'(BURST));

  // Count restarts on any grant change, in IDLE, and when a full burst re-grants the same source.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) || (w_next != r_state)) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= w_burst_done ? '0 : w_cnt_inc;
    end
  end
`else
  logic w_unused_burst;
  assign w_unused_burst = (BURST < 1);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sel   <= (w_next == S_G1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        case (i_req)
          2'b01:   w_next = S_G0;
          2'b10:   w_next = S_G1;
          2'b11:   w_next = r_lp ? S_G0 : S_G1;
          default: w_next = S_IDLE;
        endcase
      end
      S_G0, S_G1: begin
        if (!w_req_k) begin
          w_next = w_req_o ? w_other : S_IDLE;
        end else if (w_xfer) begin
`ifdef MUX_BURST_EN
          if (w_burst_done && w_req_o) w_next = w_other;
`else
          if (w_req_o) w_next = w_other;
`endif
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack    = 2'b00;
    w_ack[0] = (r_state == S_G0) && i_req[0] && w_slot_free;
    w_ack[1] = (r_state == S_G1) && i_req[1] && w_slot_free;
  end

  // A new beat may overwrite a beat being consumed in the same cycle, so no bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      r_lp      <= 1'b1;
    end else if (w_ack[0]) begin
      r_y_valid <= 1'b1;
      r_y_data  <= i_din0;
      r_lp      <= 1'b0;
    end else if (w_ack[1]) begin
      r_y_valid <= 1'b1;
      r_y_data  <= i_din1;
      r_lp      <= 1'b1;
    end else if (r_y_valid && i_y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign o_ack       = w_ack;
  assign o_sel       = r_sel;
  assign o_y_data    = r_y_data;
  assign o_y_valid   = r_y_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_rr_selector.sv
// Directed self-checking bench for mux_rr_selector (W=4, BURST=4); expectations follow MUX_BURST_EN when defined.
module tb_mux_rr_selector;
  localparam int W = 4;
  localparam logic [1:0] ST_G0 = 2'd1;
  localparam logic [1:0] ST_G1 = 2'd2;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [1:0]   i_req;
  logic [W-1:0] i_din0;
  logic [W-1:0] i_din1;
  logic         i_y_ready;
  logic [1:0]   o_ack;
  logic         o_sel;
  logic [W-1:0] o_y_data;
  logic         o_y_valid;
  logic         o_busy;
  logic [1:0]   o_dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  mux_rr_selector #(.W(W), .BURST(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_din0(i_din0), .i_din1(i_din1),
    .o_ack(o_ack), .o_sel(o_sel), .o_y_data(o_y_data), .o_y_valid(o_y_valid),
    .i_y_ready(i_y_ready), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_req = 2'b00; i_din0 = '0; i_din1 = '0; i_y_ready = 1'b0;
    step(); step();
    i_rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_req = 2'b00; i_din0 = '0; i_din1 = '0; i_y_ready = 1'b0;
    #2;
    checks++; if (o_ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", o_ack); end
    checks++; if (o_y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%b exp=0", o_y_valid); end
    step();
    i_rst_n = 1'b1;
    i_req = 2'b11; i_din0 = 4'hA; i_din1 = 4'h5; i_y_ready = 1'b1;
    step(); step();
    checks++; if (o_y_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", o_y_valid); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_sel !== 1'b0) begin failures++; $display("FAIL async_reset_sel got=%b exp=0", o_sel); end
    checks++; if (o_y_valid !== 1'b0) begin failures++; $display("FAIL async_reset_y_valid got=%b exp=0", o_y_valid); end
    checks++; if (o_y_data !== 4'h0) begin failures++; $display("FAIL async_reset_y_data got=%h exp=0", o_y_data); end
    checks++; if (o_ack !== 2'b00) begin failures++; $display("FAIL async_reset_ack got=%b exp=00", o_ack); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", o_busy); end
    i_req = 2'b00;
    step();
    i_rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    i_y_ready = 1'b1; i_din0 = 4'h1; i_req = 2'b01;
    step();
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", o_busy); end
    checks++; if (o_sel !== 1'b0) begin failures++; $display("FAIL single_sel got=%b exp=0", o_sel); end
    checks++; if (o_ack !== 2'b01) begin failures++; $display("FAIL single_ack got=%b exp=01", o_ack); end
    checks++; if (o_y_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", o_y_valid); end
    step();
    checks++; if (o_y_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", o_y_valid); end
    checks++; if (o_y_data !== 4'h1) begin failures++; $display("FAIL single_data got=%h exp=1", o_y_data); end
    i_req = 2'b00;
    #1;
    checks++; if (o_ack !== 2'b00) begin failures++; $display("FAIL single_drop_ack got=%b exp=00", o_ack); end
    step();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", o_busy); end
    checks++; if (o_y_valid !== 1'b0) begin failures++; $display("FAIL single_consumed got=%b exp=0", o_y_valid); end
    checks++; if (o_y_data !== 4'h1) begin failures++; $display("FAIL single_data_hold got=%h exp=1", o_y_data); end
  endtask

  task automatic test_fairness();
    do_reset();
    i_y_ready = 1'b1; i_din0 = 4'hA; i_din1 = 4'h5; i_req = 2'b11;
    step();
    checks++; if (o_ack !== 2'b01) begin failures++; $display("FAIL fair_first_ack got=%b exp=01", o_ack); end
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 4'hA : 4'h5);
    for (int i = 0; i < 8; i++) begin
      step();
      exp_v = exp_q.pop_front();
      checks++; if (o_y_data !== exp_v) begin failures++; $display("FAIL fair_data[%0d] got=%h exp=%h", i, o_y_data, exp_v); end
      checks++; if (o_sel !== (i % 2 == 0)) begin failures++; $display("FAIL fair_sel[%0d] got=%b exp=%b", i, o_sel, (i % 2 == 0)); end
      checks++; if (o_ack !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL fair_ack[%0d] got=%b", i, o_ack); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_y_ready = 1'b0; i_din0 = 4'hA; i_din1 = 4'h5; i_req = 2'b11;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_ack !== 2'b00) begin failures++; $display("FAIL bp_ack[%0d] got=%b exp=00", i, o_ack); end
      checks++; if (o_y_data !== 4'hA) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=a", i, o_y_data); end
      checks++; if (o_sel !== 1'b1) begin failures++; $display("FAIL bp_sel[%0d] got=%b exp=1", i, o_sel); end
      checks++; if (o_y_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, o_y_valid); end
      step();
    end
    exp_q = '{4'hA, 4'h5, 4'hA, 4'h5, 4'hA};
    i_y_ready = 1'b1;
    #1;
    checks++; if (o_ack !== 2'b10) begin failures++; $display("FAIL bp_resume_ack got=%b exp=10", o_ack); end
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++; if (!(o_y_valid === 1'b1 && o_y_data === exp_v)) begin failures++; $display("FAIL bp_stream[%0d] got=%h/%b exp=%h/1", i, o_y_data, o_y_valid, exp_v); end
      step();
    end
  endtask

  task automatic test_burst();
    do_reset();
    i_y_ready = 1'b1; i_din0 = 4'hA; i_din1 = 4'h5; i_req = 2'b11;
    step();
    for (int i = 0; i < 16; i++) begin
`ifdef MUX_BURST_EN
      exp_q.push_back(((i / 4) % 2 == 0) ? 4'hA : 4'h5);
`else
      exp_q.push_back((i % 2 == 0) ? 4'hA : 4'h5);
`endif
    end
    for (int i = 0; i < 16; i++) begin
      step();
      exp_v = exp_q.pop_front();
      checks++; if (!(o_y_valid === 1'b1 && o_y_data === exp_v)) begin failures++; $display("FAIL burst_data[%0d] got=%h/%b exp=%h/1", i, o_y_data, o_y_valid, exp_v); end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    i_y_ready = 1'b1; i_din0 = 4'h3; i_din1 = 4'h5; i_req = 2'b01;
    step();
    checks++; if (o_dbg_state !== ST_G0) begin failures++; $display("FAIL wd_state_g0 got=%0d exp=%0d", o_dbg_state, ST_G0); end
    i_req = 2'b10;
    #1;
    checks++; if (o_ack !== 2'b00) begin failures++; $display("FAIL wd_no_ack got=%b exp=00", o_ack); end
    step();
    checks++; if (o_dbg_state !== ST_G1) begin failures++; $display("FAIL wd_state_g1 got=%0d exp=%0d", o_dbg_state, ST_G1); end
    checks++; if (o_sel !== 1'b1) begin failures++; $display("FAIL wd_sel got=%b exp=1", o_sel); end
    checks++; if (o_ack !== 2'b10) begin failures++; $display("FAIL wd_ack1 got=%b exp=10", o_ack); end
    checks++; if (o_y_valid !== 1'b0) begin failures++; $display("FAIL wd_no_beat got=%b exp=0", o_y_valid); end
    step();
    checks++; if (o_y_valid !== 1'b1) begin failures++; $display("FAIL wd_valid got=%b exp=1", o_y_valid); end
    checks++; if (o_y_data !== 4'h5) begin failures++; $display("FAIL wd_data got=%h exp=5", o_y_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_burst();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
